nn_layer_stream: RTL and testbench

- Parametrised successor to the fully-parallel layer wrapper: one fully-connected layer of NUM_NEURONS lanes consuming a streamed input vector of NUM_INPUTS beats.
- Adds a valid/ready handshake on input and output, runtime activation select, rounding and saturation, and a registered argmax index.
- Sits between layers; the final instance's argmax_idx feeds the classification result.

---
 rtl/nn_pkg.sv | 22 ++
 rtl/nn_layer_stream_if.sv | 28 ++
 rtl/nn_mac_lane.sv | 56 +++++
 rtl/nn_layer_stream.sv | 117 +++++++++++
 tb/tb_nn_layer_stream.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/nn_pkg.sv
// Shared types and fixed-point helpers for the streamed fully-connected layer.
package nn_pkg;

  typedef enum logic [2:0] {IDLE, ACCUM, BIAS, ARGMAX, OUT} state_e;
  typedef enum logic {ACT_LINEAR, ACT_RELU} act_e;

  // Working width for round/saturate; callers keep their sums below this.
  localparam int RS_W = 64;

  // Round half up at bit 'frac', arithmetic shift, clamp to a signed 'dw'-bit range.
  function automatic logic signed [RS_W-1:0] round_sat(input logic signed [RS_W-1:0] x,
                                                       input int frac, input int dw);
    logic signed [RS_W-1:0] t, hi, lo;
    t  = (x + (64'sd1 <<< (frac - 1))) >>> frac;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (t > hi)      t = hi;
    else if (t < lo) t = lo;
    return t;
  endfunction

endpackage

// File: rtl/nn_layer_stream_if.sv
// Streaming input beats, per-lane weights/bias and the result vector of one layer.
interface nn_layer_stream_if #(
  parameter int NUM_NEURONS = 10,
  parameter int data_width  = 16
);
  localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

  logic                              in_valid;
  logic                              in_ready;
  logic [data_width-1:0]             in;
  logic [NUM_NEURONS*data_width-1:0] weights;
  logic [NUM_NEURONS*data_width-1:0] bias;
  logic                              act_mode;
  logic [NUM_NEURONS*data_width-1:0] layer_out;
  logic                              out_valid;
  logic                              out_ready;
  logic [IDX_W-1:0]                  argmax_idx;

  modport slave (
    input  in_valid, in, weights, bias, act_mode, out_ready,
    output in_ready, layer_out, out_valid, argmax_idx
  );

  modport master (
    output in_valid, in, weights, bias, act_mode, out_ready,
    input  in_ready, layer_out, out_valid, argmax_idx
  );
endinterface

// File: rtl/nn_mac_lane.sv
// One neuron: streamed multiply-accumulate plus the registered bias/round/saturate/activation result.
module nn_mac_lane
  import nn_pkg::*;
#(
  parameter int DW    = 16,
  parameter int FRAC  = 12,
  parameter int ACC_W = 34
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 acc_en_i,
  input  logic                 ld_out_i,
  input  act_e                 act_i,
  input  logic signed [DW-1:0] x_i,
  input  logic signed [DW-1:0] w_i,
  input  logic signed [DW-1:0] bias_i,
  output logic signed [DW-1:0] y_o
);

  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] prod_ext, acc_q, acc_d;
  logic signed [RS_W-1:0]  sum;
  logic signed [DW-1:0]    y_d, y_q;

  assign prod     = x_i * w_i;
  assign prod_ext = {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};

  // The first beat of a vector overwrites the accumulator instead of adding.
  always_comb begin
    acc_d = acc_q;
    if (start_i)       acc_d = prod_ext;
    else if (acc_en_i) acc_d = acc_q + prod_ext;
  end

  assign sum = {{(RS_W-ACC_W){acc_q[ACC_W-1]}}, acc_q}
             + ({{(RS_W-DW){bias_i[DW-1]}}, bias_i} <<< FRAC);

  always_comb begin
    y_d = DW'(round_sat(sum, FRAC, DW));
    if (act_i == ACT_RELU && y_d[DW-1]) y_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
      y_q   <= '0;
    end else begin
      acc_q <= acc_d;
      if (ld_out_i) y_q <= y_d;
    end
  end

  assign y_o = y_q;

endmodule

// File: rtl/nn_layer_stream.sv
// Streamed fully-connected layer: beat counter/FSM, lane array, registered argmax and output handshake.
module nn_layer_stream
  import nn_pkg::*;
#(
  parameter int NUM_NEURONS      = 10,
  parameter int NUM_INPUTS       = 784,
  parameter int data_width       = 16,
  parameter int weight_int_width = 4
) (
  input logic               clk,
  input logic               rst,
  nn_layer_stream_if.slave  bus
);

  localparam int DW    = data_width;
  localparam int FRAC  = DW - weight_int_width;
  localparam int ACC_W = 2*DW + $clog2(NUM_INPUTS);
  localparam int CNT_W = $clog2(NUM_INPUTS);
  localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

  state_e                           state_q, state_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  act_e                             act_q, act_d;
  logic                             out_valid_q, out_valid_d;
  logic [IDX_W-1:0]                 idx_q, idx_d, best_idx;
  logic                             in_ready, fire, start, acc_en, ld_out;
  logic [NUM_NEURONS-1:0][DW-1:0]   y;

  assign in_ready = (state_q == IDLE) || (state_q == ACCUM);
  assign fire     = bus.in_valid && in_ready;

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    best_idx = '0;
    for (int i = 1; i < NUM_NEURONS; i++)
      if ($signed(y[i]) > $signed(y[best_idx])) best_idx = IDX_W'(i);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    act_d       = act_q;
    out_valid_d = out_valid_q;
    idx_d       = idx_q;
    start       = 1'b0;
    acc_en      = 1'b0;
    ld_out      = 1'b0;
    case (state_q)
      IDLE: if (fire) begin
        start   = 1'b1;
        act_d   = act_e'(bus.act_mode);
        cnt_d   = CNT_W'(1);
        state_d = ACCUM;
      end
      ACCUM: if (fire) begin
        acc_en = 1'b1;
        if (cnt_q == CNT_W'(NUM_INPUTS - 1)) begin
          cnt_d   = '0;
          state_d = BIAS;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BIAS: begin
        ld_out  = 1'b1;
        state_d = ARGMAX;
      end
      ARGMAX: begin
        idx_d       = best_idx;
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: if (bus.out_ready) begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      act_q       <= ACT_LINEAR;
      out_valid_q <= 1'b0;
      idx_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      act_q       <= act_d;
      out_valid_q <= out_valid_d;
      idx_q       <= idx_d;
    end
  end

  for (genvar i = 0; i < NUM_NEURONS; i++) begin : g_lane
    nn_mac_lane #(.DW(DW), .FRAC(FRAC), .ACC_W(ACC_W)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .start_i  (start),
      .acc_en_i (acc_en),
      .ld_out_i (ld_out),
      .act_i    (act_q),
      .x_i      (bus.in),
      .w_i      (bus.weights[i*DW +: DW]),
      .bias_i   (bus.bias[i*DW +: DW]),
      .y_o      (y[i])
    );
  end

  assign bus.in_ready   = in_ready;
  assign bus.layer_out  = y;
  assign bus.out_valid  = out_valid_q;
  assign bus.argmax_idx = idx_q;

endmodule

// File: tb/tb_nn_layer_stream.sv
// Randomized bench for nn_layer_stream against an arithmetic model of the layer.
module tb_nn_layer_stream;
  localparam int NN = 3, NI = 4, DW = 16, WI = 4, FRAC = DW - WI;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  nn_layer_stream_if #(.NUM_NEURONS(NN), .data_width(DW)) bus();

  nn_layer_stream #(.NUM_NEURONS(NN), .NUM_INPUTS(NI), .data_width(DW), .weight_int_width(WI)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0, failures = 0;

  logic signed [DW-1:0] xs [NI];
  logic signed [DW-1:0] ws [NI][NN];
  logic signed [DW-1:0] bs [NN];
  logic                 act;
  logic [DW-1:0]        exp_y [NN];
  int                   exp_idx;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Dot product, add bias, round half up, clamp, optional ReLU, then pick the first maximum.
  function automatic void model();
    longint acc, r;
    for (int l = 0; l < NN; l++) begin
      acc = 0;
      for (int b = 0; b < NI; b++) acc += longint'(xs[b]) * longint'(ws[b][l]);
      r = (acc + longint'(bs[l]) * 4096 + 2048) >>> FRAC;
      if (r > 32767)  r = 32767;
      if (r < -32768) r = -32768;
      if (act && r < 0) r = 0;
      exp_y[l] = r[DW-1:0];
    end
    exp_idx = 0;
    for (int l = 1; l < NN; l++)
      if ($signed(exp_y[l]) > $signed(exp_y[exp_idx])) exp_idx = l;
  endfunction

  function automatic logic signed [DW-1:0] rnd();
    int v;
    v = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 4095)) - 2048
                                    : int'($urandom_range(0, 65535)) - 32768;
    return DW'(v);
  endfunction

  task automatic noise();
    bus.in       = DW'($urandom);
    bus.weights  = {$urandom, $urandom};
    bus.act_mode = 1'($urandom);
  endtask

  task automatic set_uniform(input logic signed [DW-1:0] x, input logic signed [DW-1:0] w0,
                             input logic signed [DW-1:0] w1, input logic signed [DW-1:0] w2);
    for (int b = 0; b < NI; b++) begin
      xs[b] = x;
      ws[b][0] = w0; ws[b][1] = w1; ws[b][2] = w2;
    end
    for (int l = 0; l < NN; l++) bs[l] = '0;
  endtask

  task automatic drive_beat(input int b, input logic am);
    bus.in_valid = 1'b1;
    bus.in       = xs[b];
    for (int l = 0; l < NN; l++) bus.weights[l*DW +: DW] = ws[b][l];
    bus.act_mode = am;
  endtask

  task automatic check_outputs(input string tag);
    for (int l = 0; l < NN; l++)
      check($sformatf("%s_lane%0d", tag, l), 64'(bus.layer_out[l*DW +: DW]), 64'(exp_y[l]));
    check({tag, "_argmax"}, 64'(bus.argmax_idx), 64'(exp_idx));
  endtask

  task automatic run_vector(input int bubbles, input bit toggle_act, input int hold);
    int lat;
    model();
    bus.out_ready = (hold == 0);
    for (int l = 0; l < NN; l++) bus.bias[l*DW +: DW] = bs[l];
    for (int b = 0; b < NI; b++) begin
      if (b > 0) repeat (bubbles) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
        noise();
      end
      @(negedge clk);
      check("in_ready_beat", 64'(bus.in_ready), 64'd1);
      drive_beat(b, (b > 0 && toggle_act) ? ~act : act);
      @(posedge clk);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    noise();
    lat = 1;
    @(posedge clk); #1;
    while (!bus.out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 64'(lat), 64'd2);
    check_outputs("result");
    check("in_ready_pending", 64'(bus.in_ready), 64'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      noise();
      @(posedge clk); #1;
      check("hold_valid", 64'(bus.out_valid), 64'd1);
      check("hold_in_ready", 64'(bus.in_ready), 64'd0);
      check_outputs("hold");
    end
    if (hold > 0) begin
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check("consumed_valid", 64'(bus.out_valid), 64'd0);
    check("consumed_in_ready", 64'(bus.in_ready), 64'd1);
    check_outputs("kept");
  endtask

  task automatic random_vector();
    for (int b = 0; b < NI; b++) begin
      xs[b] = rnd();
      for (int l = 0; l < NN; l++) ws[b][l] = rnd();
    end
    for (int l = 0; l < NN; l++) bs[l] = rnd();
    act = 1'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    bus.in_valid = 1'b0; bus.in = '0; bus.weights = '0; bus.bias = '0;
    bus.act_mode = 1'b0; bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_layer_out", 64'(bus.layer_out), 64'd0);
    check("rst_argmax", 64'(bus.argmax_idx), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);

    set_uniform(16'sh1000, 16'sh0800, -16'sh0400, 16'sh1000); act = 1'b0;
    run_vector(0, 1'b0, 0);
    act = 1'b1;
    run_vector(0, 1'b1, 0);

    set_uniform(16'sh7000, 16'sh7000, -16'sh7000, 16'sh0800); act = 1'b0;
    run_vector(0, 1'b0, 0);
    set_uniform(16'sh0000, 16'sh0800, 16'sh0800, 16'sh0800);
    xs[0] = 16'sh0001;
    run_vector(0, 1'b0, 0);

    random_vector();
    run_vector(0, 1'b0, 5);
    set_uniform(16'sh1000, 16'sh0800, -16'sh0400, 16'sh1000); act = 1'b0;
    run_vector(3, 1'b0, 0);
    set_uniform(16'sh1000, 16'sh0400, 16'sh0400, 16'sh0000);
    run_vector(0, 1'b0, 0);

    // Partial vector interrupted by reset; the next full vector must start from beat 0.
    set_uniform(16'sh1000, 16'sh0800, -16'sh0400, 16'sh1000); act = 1'b0;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      drive_beat(b, act);
      @(posedge clk);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("midrst_layer_out", 64'(bus.layer_out), 64'd0);
    check("midrst_argmax", 64'(bus.argmax_idx), 64'd0);
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    run_vector(0, 1'b0, 0);

    for (int n = 0; n < 14; n++) begin
      random_vector();
      run_vector(int'($urandom_range(0, 2)), 1'($urandom), int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
